mod_if_consumer: RTL and testbench
==================================

Name: mod_if_consumer

Overview:
- Downstream stage of the request/grant interface producer. Accepts `{addr, data}` transactions on `req`/`grant` and buffers them in a small FIFO.
- Drains the FIFO to a sink through a valid/ready output stage.
- Maintains a transaction counter and a running XOR checksum of accepted data for debug/observability.
- Sits between the interface producer and the register/memory sink.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.
- ADDR_W, 8, address width.
- DATA_W, 8, data width.
- CNT_W, 16, width of the accepted-transaction counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset (asserted when 0, sampled on rising edge of clk).
- req  input  1  producer request; a transaction is offered while high.
- addr  input  ADDR_W  request address, valid while req=1.
- data  input  DATA_W  request data, valid while req=1.
- grant  output  1  consumer can accept this cycle.
- out_valid  output  1  output transaction valid.
- out_ready  input  1  sink accepts output transaction.
- out_addr  output  ADDR_W  output address.
- out_data  output  DATA_W  output data.
- fill  output  $clog2(DEPTH)+1  current FIFO occupancy.
- acc_cnt  output  CNT_W  accepted transactions, saturating.
- csum  output  DATA_W  XOR of all accepted data since reset.

Behaviour:
- Reset (rst=0 at a clock edge):
  - FIFO emptied; fill=0; out_valid=0; out_addr=0; out_data=0; acc_cnt=0; csum=0; FSM=IDLE.
  - grant=0 during reset cycles.
- grant is combinational: grant = rst & (fill < DEPTH).
  - It does not depend on req, so the producer may use grant combinationally to modify data in the same cycle.
- Accept: req & grant at a clock edge pushes `{addr, data}` sampled in that cycle.
  - Producers that change data based on grant deliver the modified value.
- On accept:
  - acc_cnt += 1, saturating at 2^CNT_W−1.
  - csum ^= data.
  - Both update on the same edge as the push.
- FIFO full (fill=DEPTH): grant=0; req is ignored; nothing is dropped, the producer holds.
- Simultaneous push and pop when full: not permitted. grant is already 0, so a pop frees a slot only for the next cycle.
- Simultaneous push and pop when non-full: fill unchanged, both take effect.
- Output FSM:
  - IDLE: out_valid=0. If FIFO non-empty, pop head into out_addr/out_data registers and go to VALID. out_valid rises the cycle after the head is present, giving minimum latency accept→out_valid = 2 cycles.
  - VALID: out_valid=1; out_addr/out_data are stable until handshake.
    - out_valid & out_ready and FIFO non-empty: pop next entry into the output registers, stay VALID. Back-to-back throughput is 1 per cycle.
    - out_valid & out_ready and FIFO empty: go to IDLE, out_valid=0 next cycle.
    - out_ready=0: hold all outputs.
- fill counts FIFO entries only; the output register entry is excluded. Total buffering is DEPTH+1.
- Pointers wrap modulo DEPTH; fill distinguishes full from empty.
- Reset mid-operation: all buffered and in-flight transactions are discarded. No output handshake completes on the reset edge.
- Checksum arithmetic: bitwise XOR, DATA_W wide, no carry.

Decomposition:
- Package `mod_if_pkg`:
  - typedef `if_txn_t` (packed struct `{addr, data}`, ADDR_W/DATA_W defaults 8).
  - FSM enum `out_state_e` {IDLE, VALID}.
  - Default-width localparams.
- Sub-module `mod_if_fifo`:
  - Parameterised synchronous FIFO of `if_txn_t`.
  - Ports: push, pop, wdata, rdata (head), full, empty, fill; same clk/rst convention.
- Top level holds grant logic, the output FSM, the counter and the checksum.

Test Plan:
- Single transaction: after reset, drive req=1, addr=0x12, data=0x34 for one cycle with out_ready=1.
  - Expect grant=1, fill=1 next cycle, out_valid=1 with out_addr=0x12/out_data=0x34 two cycles after accept, acc_cnt=1, csum=0x34.
- Grant-dependent data: producer drives data=0xFF whenever grant=1, req held for 3 cycles.
  - Expect three outputs all data=0xFF, acc_cnt=3, csum=0xFF.
- Backpressure/full: out_ready=0, req=1 continuously with DEPTH=4.
  - Expect grant=0 after 5 accepts (4 in FIFO + 1 in output register), fill=4, no loss.
  - Then out_ready=1: expect 5 outputs in order, then grant=1 again.
- Back-to-back streaming: req=1 and out_ready=1 for 20 cycles with addr incrementing from 0x00.
  - Expect one output per cycle after a 2-cycle latency.
  - Expect addresses 0x00..0x13 in order, with pointer wrap exercised.
- Reset mid-operation: fill=3 and out_valid=1, then rst=0 for one cycle.
  - Expect fill=0, out_valid=0, acc_cnt=0, csum=0, grant=0 during reset and grant=1 the cycle after release.
- Counter saturation with CNT_W=4: accept 20 transactions.
  - Expect acc_cnt=15 held.

Source files
------------

// File: rtl/mod_if_pkg.sv
// Shared types and default widths for the request/grant consumer slice.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mod_if_pkg;

    localparam int DEF_DEPTH  = 4;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_CNT_W  = 16;

    // One buffered transaction at the default widths.
    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
    } if_txn_t;

    // Output stage state: IDLE = output register empty, VALID = presenting a txn.
    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } out_state_e;

endpackage

// File: rtl/mod_if_consumer_if.sv
// Bus bundle: producer side (req/grant with addr/data) and sink side (valid/ready).
// Latency: n/a (wires only).
// Backpressure: grant throttles the producer, out_ready throttles the consumer output.
// Modports: master = producer + sink view, slave = consumer view.
interface mod_if_consumer_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              grant;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;

    modport master (
        output req, addr, data, out_ready,
        input  grant, out_valid, out_addr, out_data
    );

    modport slave (
        input  req, addr, data, out_ready,
        output grant, out_valid, out_addr, out_data
    );
endinterface

// File: rtl/mod_if_fifo.sv
// Synchronous FIFO of transactions with occupancy output.
// Latency: push visible at head the cycle after the write edge; rdata shows head combinationally.
// Backpressure: push ignored when full, pop ignored when empty; caller gates with full/empty.
// Ports: clk, rst (sync active-low), push/wdata, pop/rdata, full, empty, fill.
module mod_if_fifo
    import mod_if_pkg::*;
#(
    parameter int  DEPTH = DEF_DEPTH,
    parameter type T     = if_txn_t,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int FILL_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  T                  wdata,
    output T                  rdata,
    output logic              full,
    output logic              empty,
    output logic [FILL_W-1:0] fill
);

    T                  mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (fill == FILL_W'(DEPTH));
    assign empty   = (fill == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // Storage needs no reset; only pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
        end
    end

endmodule

// File: rtl/mod_if_consumer.sv
// Consumer of req/grant transactions: FIFO buffer, valid/ready output register, debug counter and XOR checksum.
// Latency: 2 cycles accept -> out_valid minimum; 1 txn/cycle sustained.
// Backpressure: grant drops when the FIFO is full; out_valid holds data until out_ready.
// Ports: clk, rst (sync active-low), bus (slave modport), fill, acc_cnt (saturating), csum.
module mod_if_consumer
    import mod_if_pkg::*;
#(
    parameter int  DEPTH  = DEF_DEPTH,
    parameter int  ADDR_W = DEF_ADDR_W,
    parameter int  DATA_W = DEF_DATA_W,
    parameter int  CNT_W  = DEF_CNT_W,
    localparam int FILL_W = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    mod_if_consumer_if.slave    bus,
    output logic [FILL_W-1:0]   fill,
    output logic [CNT_W-1:0]    acc_cnt,
    output logic [DATA_W-1:0]   csum
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } txn_t;

    out_state_e        state;
    logic              out_vld_q;
    logic [ADDR_W-1:0] out_addr_q;
    logic [DATA_W-1:0] out_data_q;

    txn_t              wdata;
    txn_t              head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;

    // grant depends only on reset and occupancy, never on req, so a producer
    // may steer its data from grant within the same cycle.
    assign bus.grant = rst & ~fifo_full;
    assign push      = bus.req & bus.grant;
    assign wdata     = {bus.addr, bus.data};

    // Refill the output register when it is empty or is being drained this cycle.
    assign pop = rst & ~fifo_empty & ((state == IDLE) | bus.out_ready);

    mod_if_fifo #(
        .DEPTH (DEPTH),
        .T     (txn_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .fill  (fill)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            out_vld_q  <= 1'b0;
            out_addr_q <= '0;
            out_data_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        out_addr_q <= head.addr;
                        out_data_q <= head.data;
                        out_vld_q  <= 1'b1;
                        state      <= VALID;
                    end
                end
                VALID: begin
                    if (bus.out_ready) begin
                        if (!fifo_empty) begin
                            out_addr_q <= head.addr;
                            out_data_q <= head.data;
                        end else begin
                            out_vld_q <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_vld_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out_valid = out_vld_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_data  = out_data_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_cnt <= '0;
            csum    <= '0;
        end else if (push) begin
            if (acc_cnt != {CNT_W{1'b1}}) begin
                acc_cnt <= acc_cnt + 1'b1;
            end
            csum <= csum ^ bus.data;
        end
    end

endmodule

// File: tb/tb_mod_if_consumer.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-level model.
// Two instances share stimulus: default counter width and a 4-bit counter for saturation.
module tb_mod_if_consumer;
    import mod_if_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int FW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;

    mod_if_consumer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    mod_if_consumer_if #(.ADDR_W(AW), .DATA_W(DW)) bus_s ();

    logic [FW-1:0] fill, fill_s;
    logic [15:0]   acc_cnt;
    logic [3:0]    acc_cnt_s;
    logic [DW-1:0] csum, csum_s;

    mod_if_consumer #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW), .CNT_W(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .fill    (fill),
        .acc_cnt (acc_cnt),
        .csum    (csum)
    );

    mod_if_consumer #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW), .CNT_W(4)) dut_s (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus_s),
        .fill    (fill_s),
        .acc_cnt (acc_cnt_s),
        .csum    (csum_s)
    );

    assign bus_s.req       = bus.req;
    assign bus_s.addr      = bus.addr;
    assign bus_s.data      = bus.data;
    assign bus_s.out_ready = bus.out_ready;

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit gd_mode = 1'b0;

    // Reference model: FIFO contents as a queue, plus one output slot.
    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } item_t;

    item_t         mq[$];
    bit            m_vld   = 1'b0;
    item_t         m_reg   = '0;
    int            m_total = 0;
    logic [DW-1:0] m_csum  = '0;

    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: settle inputs, compare DUT against model, advance model, clock.
    task automatic step();
        bit exp_grant, hs, do_push, do_pop;
        #1;
        if (gd_mode) bus.data = bus.grant ? 8'hFF : 8'h00;
        #1;
        exp_grant = rst && (mq.size() < DEPTH);
        check("grant",       32'(bus.grant),     32'(exp_grant));
        check("fill",        32'(fill),          mq.size());
        check("out_valid",   32'(bus.out_valid), 32'(m_vld));
        check("out_addr",    32'(bus.out_addr),  32'(m_reg.a));
        check("out_data",    32'(bus.out_data),  32'(m_reg.d));
        check("acc_cnt",     32'(acc_cnt),       sat(m_total, 65535));
        check("csum",        32'(csum),          32'(m_csum));
        check("acc_cnt_sat", 32'(acc_cnt_s),     sat(m_total, 15));
        check("out_valid_s", 32'(bus_s.out_valid), 32'(m_vld));

        if (!rst) begin
            mq.delete();
            m_vld   = 1'b0;
            m_reg   = '0;
            m_total = 0;
            m_csum  = '0;
        end else begin
            hs      = m_vld && bus.out_ready;
            do_push = bus.req && exp_grant;
            do_pop  = (mq.size() > 0) && (!m_vld || hs);
            if (do_pop) begin
                m_reg = mq.pop_front();
                m_vld = 1'b1;
            end else if (hs) begin
                m_vld = 1'b0;
            end
            if (do_push) begin
                mq.push_back({bus.addr, bus.data});
                m_total++;
                m_csum ^= bus.data;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.req       = 1'b0;
        bus.addr      = '0;
        bus.data      = '0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset state
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;

        // Single transaction
        bus.req = 1'b1; bus.addr = 8'h12; bus.data = 8'h34;
        step();
        bus.req = 1'b0;
        repeat (4) step();
        check("single_acc", 32'(acc_cnt), 32'd1);
        check("single_csum", 32'(csum), 32'h34);

        // Grant-steered data after a fresh reset
        rst = 1'b0;
        step();
        rst = 1'b1;
        gd_mode = 1'b1;
        bus.req = 1'b1; bus.addr = 8'h40;
        repeat (3) step();
        bus.req = 1'b0;
        gd_mode = 1'b0;
        repeat (5) step();
        check("gd_acc", 32'(acc_cnt), 32'd3);
        check("gd_csum", 32'(csum), 32'hFF);

        // Backpressure until full, then drain
        bus.out_ready = 1'b0;
        bus.req = 1'b1;
        repeat (8) begin
            bus.addr = 8'($urandom);
            bus.data = 8'($urandom);
            step();
        end
        check("full_fill", 32'(fill), 32'd4);
        check("full_grant", 32'(bus.grant), 32'd0);
        check("full_acc", 32'(acc_cnt), 32'd8);
        bus.req = 1'b0;
        bus.out_ready = 1'b1;
        repeat (7) step();
        check("drain_grant", 32'(bus.grant), 32'd1);

        // Back-to-back streaming with pointer wrap
        bus.req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.addr = 8'(i);
            bus.data = 8'($urandom);
            step();
        end
        bus.req = 1'b0;
        repeat (4) step();

        // Reset mid-operation with fill=3 and out_valid=1
        bus.out_ready = 1'b0;
        bus.req = 1'b1;
        repeat (4) begin
            bus.addr = 8'($urandom);
            bus.data = 8'($urandom);
            step();
        end
        bus.req = 1'b0;
        check("mid_fill", 32'(fill), 32'd3);
        check("mid_valid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        rst = 1'b0;
        step();
        rst = 1'b1;
        #1;
        check("rst_fill", 32'(fill), 32'd0);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_acc", 32'(acc_cnt), 32'd0);
        check("rst_csum", 32'(csum), 32'd0);
        check("rst_grant", 32'(bus.grant), 32'd1);

        // Counter saturation on the 4-bit instance
        bus.req = 1'b1;
        repeat (20) begin
            bus.addr = 8'($urandom);
            bus.data = 8'($urandom);
            step();
        end
        bus.req = 1'b0;
        repeat (3) step();
        check("sat_acc_s", 32'(acc_cnt_s), 32'd15);
        check("sat_acc", 32'(acc_cnt), 32'd20);

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            rst           = ($urandom_range(0, 99) != 0);
            bus.req       = ($urandom_range(0, 3) != 0);
            bus.addr      = 8'($urandom);
            bus.data      = 8'($urandom);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        rst = 1'b1;
        bus.req = 1'b0;
        bus.out_ready = 1'b1;
        repeat (8) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
